hazard_forward_unit: RTL and testbench

Parametrised data-hazard, forwarding and stall controller between decode and the execute/memory stages of the in-order integer pipeline. It keeps a scoreboard of in-flight writers, selects a forwarded operand for each decode source from the youngest matching stage, and inserts load-use bubbles. It also holds decode for FENCE until in-flight memory operations drain.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_forward_unit_if.sv | 39 +++
 rtl/fwd_priority_mux.sv | 34 +++
 rtl/hazard_forward_unit.sv | 172 +++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/forwarding controller
package hazard_pkg;

    // Scoreboard rd container; the top zero-extends REG_ADDR_W (<= RD_W) into it
    localparam int RD_W   = 8;
    localparam int FWD_RF = 0;

    // Major opcodes the integrating decoder uses to derive is_load/is_mem/is_fence
    localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
    localparam logic [6:0] OPC_STORE    = 7'b010_0011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
    localparam logic [6:0] OPC_OP       = 7'b011_0011;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            is_load;
        logic            is_mem;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FENCE_DRAIN = 2'd1
    } fsm_state_t;

    function automatic logic sb_hit(input sb_entry_t e, input logic [RD_W-1:0] rs);
        return e.valid && e.we && (e.rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - decode/stage/forwarding bundle between the pipeline and the hazard unit
interface hazard_forward_unit_if #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2
) ();
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic                          ext_stall;
    logic                          dec_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] dec_rs;
    logic [REG_ADDR_W-1:0]         dec_rd;
    logic                          dec_rd_we;
    logic                          dec_is_load;
    logic                          dec_is_mem;
    logic                          dec_is_fence;
    logic [NUM_SRC*XLEN-1:0]       dec_operand;
    logic [FWD_DEPTH*XLEN-1:0]     stage_result;
    logic [NUM_SRC*XLEN-1:0]       fwd_operand;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic                          f_to_d_enable;
    logic                          d_to_e_enable;
    logic                          bubble;
    logic                          fence_busy;

    modport master (
        output ext_stall, dec_valid, dec_rs, dec_rd, dec_rd_we, dec_is_load,
               dec_is_mem, dec_is_fence, dec_operand, stage_result,
        input  fwd_operand, fwd_sel, f_to_d_enable, d_to_e_enable, bubble, fence_busy
    );

    modport slave (
        input  ext_stall, dec_valid, dec_rs, dec_rd, dec_rd_we, dec_is_load,
               dec_is_mem, dec_is_fence, dec_operand, stage_result,
        output fwd_operand, fwd_sel, f_to_d_enable, d_to_e_enable, bubble, fence_busy
    );

endinterface

// File: rtl/fwd_priority_mux.sv
// rtl/fwd_priority_mux.sv - youngest-match forward select, operand mux and load-use flag for one source
module fwd_priority_mux
    import hazard_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic [REG_ADDR_W-1:0]     rs_i,
    input  logic [XLEN-1:0]           rf_operand_i,
    input  sb_entry_t                 sb_i [FWD_DEPTH],
    input  logic [FWD_DEPTH*XLEN-1:0] stage_result_i,
    output logic [SEL_W-1:0]          sel_o,
    output logic [XLEN-1:0]           operand_o,
    output logic                      load_haz_o
);

    // Scan oldest to youngest so the youngest matching stage is the last writer
    always_comb begin
        sel_o      = SEL_W'(FWD_RF);
        operand_o  = rf_operand_i;
        load_haz_o = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (sb_hit(sb_i[k-1], RD_W'(rs_i))) begin
                sel_o      = SEL_W'(k);
                operand_o  = stage_result_i[(k-1)*XLEN +: XLEN];
                load_haz_o = sb_i[k-1].is_load && (k < LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - scoreboard, operand forwarding, load-use and FENCE stall control
// Optional HAZARD_PERF_CNT_EN adds saturating load/fence stall-cycle counters.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_unit_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          load_stall_cnt,
    output logic [31:0]          fence_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(FWD_DEPTH + 2);

    sb_entry_t        sb_q   [FWD_DEPTH];
    sb_entry_t        sb_eff [FWD_DEPTH];
    sb_entry_t        dec_entry;
    logic [SEL_W-1:0] sel_w  [NUM_SRC];
    logic [XLEN-1:0]  op_w   [NUM_SRC];
    logic [NUM_SRC-1:0] haz_w;

    logic             any_mem;
    logic             load_haz;
    logic             fence_start;
    logic             fence_hold;
    logic             stall;

    fsm_state_t       state_q;
    logic             fence_busy_q;
    logic [CNT_W-1:0] drain_cnt_q;

    // Masking the scoreboard under rst forces register-file selects without waiting a cycle
    always_comb begin
        any_mem = 1'b0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            sb_eff[k] = rst ? '0 : sb_q[k];
            any_mem   = any_mem | (sb_eff[k].valid & sb_eff[k].is_mem);
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_priority_mux #(
            .XLEN       (XLEN),
            .REG_ADDR_W (REG_ADDR_W),
            .FWD_DEPTH  (FWD_DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .SEL_W      (SEL_W)
        ) u_mux (
            .rs_i           (bus.dec_rs[s*REG_ADDR_W +: REG_ADDR_W]),
            .rf_operand_i   (bus.dec_operand[s*XLEN +: XLEN]),
            .sb_i           (sb_eff),
            .stage_result_i (bus.stage_result),
            .sel_o          (sel_w[s]),
            .operand_o      (op_w[s]),
            .load_haz_o     (haz_w[s])
        );
    end

    assign load_haz    = |haz_w;
    assign fence_start = bus.dec_valid && bus.dec_is_fence && any_mem;
    assign fence_hold  = (state_q == FENCE_DRAIN) ? any_mem : fence_start;
    assign stall       = !rst && bus.dec_valid && (load_haz || fence_hold);

    always_comb begin
        dec_entry         = '0;
        dec_entry.valid   = 1'b1;
        dec_entry.rd      = RD_W'(bus.dec_rd);
        dec_entry.we      = bus.dec_rd_we;
        dec_entry.is_load = bus.dec_is_load;
        dec_entry.is_mem  = bus.dec_is_mem;
    end

    always_comb begin
        bus.fwd_sel     = '0;
        bus.fwd_operand = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            bus.fwd_sel[s*SEL_W +: SEL_W]    = sel_w[s];
            bus.fwd_operand[s*XLEN +: XLEN] = op_w[s];
        end
    end

    // ext_stall outranks a hazard stall: nothing moves, so no bubble is injected
    always_comb begin
        bus.f_to_d_enable = 1'b1;
        bus.d_to_e_enable = 1'b1;
        bus.bubble        = 1'b0;
        if (!rst) begin
            if (bus.ext_stall) begin
                bus.f_to_d_enable = 1'b0;
                bus.d_to_e_enable = 1'b0;
            end else if (stall) begin
                bus.f_to_d_enable = 1'b0;
                bus.d_to_e_enable = 1'b0;
                bus.bubble        = 1'b1;
            end
        end
    end

    assign bus.fence_busy = fence_busy_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                sb_q[k] <= '0;
            end
        end else if (!bus.ext_stall) begin
            for (int k = 1; k < FWD_DEPTH; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
            sb_q[0] <= (bus.dec_valid && !stall) ? dec_entry : '0;
        end
    end

    // Stalled decode feeds bubbles, so in-flight mem ops leave within FWD_DEPTH drain cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fence_busy_q <= 1'b0;
            drain_cnt_q  <= '0;
        end else if (!bus.ext_stall) begin
            case (state_q)
                IDLE: begin
                    if (fence_start) begin
                        state_q      <= FENCE_DRAIN;
                        fence_busy_q <= 1'b1;
                        drain_cnt_q  <= '0;
                    end
                end
                FENCE_DRAIN: begin
                    if (drain_cnt_q != '1) begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                    if (!any_mem) begin
                        state_q      <= IDLE;
                        fence_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    fence_busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            load_stall_cnt  <= '0;
            fence_stall_cnt <= '0;
        end else if (!bus.ext_stall && bus.dec_valid) begin
            if (load_haz && load_stall_cnt != '1) begin
                load_stall_cnt <= load_stall_cnt + 32'd1;
            end
            if (fence_hold && fence_stall_cnt != '1) begin
                fence_stall_cnt <= fence_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed and randomized checks of hazard_forward_unit against a queue model
module tb_hazard_forward_unit;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_SRC    = 2;
    localparam int FWD_DEPTH  = 2;
    localparam int LOAD_STAGE = 2;
    localparam int SEL_W      = $clog2(FWD_DEPTH + 1);

    logic clk = 1'b0;
    logic rst;

    hazard_forward_unit_if #(
        .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC), .FWD_DEPTH(FWD_DEPTH)
    ) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] load_stall_cnt;
    logic [31:0] fence_stall_cnt;
`endif

    hazard_forward_unit #(
        .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC),
        .FWD_DEPTH(FWD_DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .load_stall_cnt  (load_stall_cnt),
        .fence_stall_cnt (fence_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // In-flight instruction records; pipe[0] is the execute stage
    typedef struct {
        bit          valid;
        int unsigned rd;
        bit          we;
        bit          ld;
        bit          mem;
    } rec_t;

    rec_t        pipe[$];
    bit          draining;
    longint      m_load_cnt;
    longint      m_fence_cnt;

    task automatic clear_model();
        rec_t empty;
        empty = '{valid: 1'b0, rd: 0, we: 1'b0, ld: 1'b0, mem: 1'b0};
        pipe.delete();
        for (int i = 0; i < FWD_DEPTH; i++) pipe.push_back(empty);
        draining    = 1'b0;
        m_load_cnt  = 0;
        m_fence_cnt = 0;
    endtask

    task automatic drive(input bit v, input int rs0, input int rs1, input int rd,
                         input bit we, input bit ld, input bit mem, input bit fence);
        bus.dec_valid    = v;
        bus.dec_rs       = {REG_ADDR_W'(rs1), REG_ADDR_W'(rs0)};
        bus.dec_rd       = REG_ADDR_W'(rd);
        bus.dec_rd_we    = we;
        bus.dec_is_load  = ld;
        bus.dec_is_mem   = mem;
        bus.dec_is_fence = fence;
        bus.dec_operand  = {$urandom, $urandom, $urandom, $urandom};
        bus.stage_result = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Compares every output against the model, then advances the model across one clock edge
    task automatic tick();
        bit          haz, any_mem, fhold, stall, nxt_drain;
        int          e_sel, rs;
        logic [63:0] e_op;
        rec_t        nrec;
        #1;
        haz     = 1'b0;
        any_mem = 1'b0;
        if (!rst) foreach (pipe[k]) if (pipe[k].valid && pipe[k].mem) any_mem = 1'b1;
        for (int s = 0; s < NUM_SRC; s++) begin
            rs    = int'(bus.dec_rs[s*REG_ADDR_W +: REG_ADDR_W]);
            e_sel = 0;
            e_op  = bus.dec_operand[s*XLEN +: XLEN];
            if (!rst) begin
                for (int k = 0; k < FWD_DEPTH; k++) begin
                    if (pipe[k].valid && pipe[k].we && pipe[k].rd == rs && rs != 0) begin
                        e_sel = k + 1;
                        e_op  = bus.stage_result[k*XLEN +: XLEN];
                        if (pipe[k].ld && (k + 1) < LOAD_STAGE) haz = 1'b1;
                        break;
                    end
                end
            end
            check_eq($sformatf("fwd_sel[%0d]", s), 64'(bus.fwd_sel[s*SEL_W +: SEL_W]), 64'(e_sel));
            check_eq($sformatf("fwd_operand[%0d]", s), bus.fwd_operand[s*XLEN +: XLEN], e_op);
        end
        fhold = draining ? any_mem : (bus.dec_valid && bus.dec_is_fence && any_mem);
        if (rst) fhold = 1'b0;
        stall = bus.dec_valid && (haz || fhold) && !rst;
        if (rst) begin
            check_eq("f_to_d_enable", 64'(bus.f_to_d_enable), 64'd1);
            check_eq("d_to_e_enable", 64'(bus.d_to_e_enable), 64'd1);
            check_eq("bubble", 64'(bus.bubble), 64'd0);
        end else begin
            check_eq("f_to_d_enable", 64'(bus.f_to_d_enable), 64'(!bus.ext_stall && !stall));
            check_eq("d_to_e_enable", 64'(bus.d_to_e_enable), 64'(!bus.ext_stall && !stall));
            check_eq("bubble", 64'(bus.bubble), 64'(!bus.ext_stall && stall));
        end
        check_eq("fence_busy", 64'(bus.fence_busy), 64'(draining && !rst));
        if (!rst) begin
            check_eq("drain_cnt_bound", 64'(dut.drain_cnt_q <= FWD_DEPTH), 64'd1);
`ifdef HAZARD_PERF_CNT_EN
            check_eq("load_stall_cnt", 64'(load_stall_cnt), 64'(m_load_cnt));
            check_eq("fence_stall_cnt", 64'(fence_stall_cnt), 64'(m_fence_cnt));
`endif
        end
        nxt_drain = draining ? any_mem : (bus.dec_valid && bus.dec_is_fence && any_mem);
        nrec = '{valid: bus.dec_valid && !stall, rd: int'(bus.dec_rd), we: bus.dec_rd_we,
                 ld: bus.dec_is_load, mem: bus.dec_is_mem};
        if (!nrec.valid) nrec = '{valid: 1'b0, rd: 0, we: 1'b0, ld: 1'b0, mem: 1'b0};
        @(posedge clk);
        if (rst) begin
            clear_model();
        end else if (!bus.ext_stall) begin
            if (bus.dec_valid && haz && m_load_cnt < 64'hFFFF_FFFF) m_load_cnt++;
            if (bus.dec_valid && fhold && m_fence_cnt < 64'hFFFF_FFFF) m_fence_cnt++;
            draining = nxt_drain;
            pipe.push_front(nrec);
            void'(pipe.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic flush();
        for (int i = 0; i < FWD_DEPTH + 1; i++) begin
            drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [63:0] v;
        int          kind;
        rst           = 1'b1;
        bus.ext_stall = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_model();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // addi x5 ; add x6,x5,x5
        drive(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5, 5, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        v = bus.stage_result[XLEN-1:0];
        #1;
        check_eq("alu_fwd_sel0", 64'(bus.fwd_sel[SEL_W-1:0]), 64'd1);
        check_eq("alu_fwd_sel1", 64'(bus.fwd_sel[2*SEL_W-1:SEL_W]), 64'd1);
        check_eq("alu_fwd_op1", bus.fwd_operand[2*XLEN-1:XLEN], v);
        check_eq("alu_no_stall", 64'(bus.bubble), 64'd0);
        tick();

        // ld x7 ; add x8,x7,x0 -> one bubble then forward from the load stage
        flush();
        drive(1'b1, 0, 0, 7, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 7, 0, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("lu_bubble", 64'(bus.bubble), 64'd1);
        check_eq("lu_d_to_e", 64'(bus.d_to_e_enable), 64'd0);
        tick();
        drive(1'b1, 7, 0, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.stage_result[2*XLEN-1:XLEN] = 64'hDEAD_BEEF;
        #1;
        check_eq("lu_fwd_sel0", 64'(bus.fwd_sel[SEL_W-1:0]), 64'd2);
        check_eq("lu_fwd_op0", bus.fwd_operand[XLEN-1:0], 64'hDEAD_BEEF);
        check_eq("lu_released", 64'(bus.bubble), 64'd0);
        tick();

        // writers of x0 never forward
        flush();
        drive(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 0, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.dec_operand = '0;
        #1;
        check_eq("x0_sel", 64'(bus.fwd_sel), 64'd0);
        check_eq("x0_op", bus.fwd_operand[XLEN-1:0], 64'd0);
        tick();

        // sd ; FENCE -> two drain cycles, FENCE advances on the third
        flush();
        drive(1'b1, 1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check_eq("fence_c0_bubble", 64'(bus.bubble), 64'd1);
        check_eq("fence_c0_busy", 64'(bus.fence_busy), 64'd0);
        tick();
        #1;
        check_eq("fence_c1_busy", 64'(bus.fence_busy), 64'd1);
        check_eq("fence_c1_bubble", 64'(bus.bubble), 64'd1);
        tick();
        #1;
        check_eq("fence_c2_busy", 64'(bus.fence_busy), 64'd1);
        check_eq("fence_c2_advance", 64'(bus.f_to_d_enable), 64'd1);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("fence_done_busy", 64'(bus.fence_busy), 64'd0);
        tick();

        // ld x9 frozen by ext_stall for 3 cycles, then a single load-use stall
        flush();
        drive(1'b1, 0, 0, 9, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        bus.ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 9, 0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            check_eq("ext_bubble", 64'(bus.bubble), 64'd0);
            check_eq("ext_frozen_sel", 64'(bus.fwd_sel[SEL_W-1:0]), 64'd1);
            tick();
        end
        bus.ext_stall = 1'b0;
        drive(1'b1, 9, 0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("ext_release_bubble", 64'(bus.bubble), 64'd1);
        tick();
        drive(1'b1, 9, 0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("ext_after_sel", 64'(bus.fwd_sel[SEL_W-1:0]), 64'd2);
        tick();

        // reset in the middle of a drain
        flush();
        drive(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        bus.ext_stall = 1'b1;
        tick();
        rst = 1'b0;
        bus.ext_stall = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("rst_busy", 64'(bus.fence_busy), 64'd0);
        check_eq("rst_f_to_d", 64'(bus.f_to_d_enable), 64'd1);
        check_eq("rst_d_to_e", 64'(bus.d_to_e_enable), 64'd1);
        check_eq("rst_sel", 64'(bus.fwd_sel), 64'd0);
`ifdef HAZARD_PERF_CNT_EN
        check_eq("rst_load_cnt", 64'(load_stall_cnt), 64'd0);
        check_eq("rst_fence_cnt", 64'(fence_stall_cnt), 64'd0);
`endif
        tick();

        // randomized traffic over a small register set to provoke matches
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            bus.ext_stall = ($urandom_range(0, 99) < 15);
            kind = int'($urandom_range(0, 5));
            case (kind)
                0, 1: drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), 1'b1, 1'b0, 1'b0, 1'b0);
                2:    drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), 1'b1, 1'b1, 1'b1, 1'b0);
                3:    drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                            0, 1'b0, 1'b0, 1'b1, 1'b0);
                4:    drive($urandom_range(0, 9) != 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
                default: drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                               $urandom_range(0, 3), $urandom_range(0, 1) != 0, 1'b0, 1'b0, 1'b0);
            endcase
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
